l2_ic_resp: RTL and testbench

//  L2-side responder for the L1 icache refill interface; the far end of irq/l2_addr_ic/l2_busy/l2_rdy.

---
 rtl/l2_ic_resp.sv | 133 +++++++++++++
 tb/tb_l2_ic_resp.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/l2_ic_resp.sv
// L2-side responder for the L1 icache refill port: fetches a line as BEATS memory beats and holds it until complete_ic.
// Optional one-entry line buffer enabled by defining L2IC_LINEBUF_EN.
`ifndef READ
`define READ 1'b1
`endif
`ifndef WRITE
`define WRITE 1'b0
`endif

module l2_ic_resp #(
  parameter int unsigned LINE_ADDR_W = 28,
  parameter int unsigned WORD_W      = 32,
  parameter int unsigned BEATS       = 4
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   irq,
  input  logic [LINE_ADDR_W-1:0]                 l2_addr_ic,
  input  logic                                   l2_cache_rw_ic,
  input  logic                                   complete_ic,
  output logic                                   l2_busy,
  output logic                                   l2_rdy,
  output logic                                   mem_wr_ic_en,
  output logic [WORD_W*BEATS-1:0]                data_wd_l2,
  output logic                                   mem_req,
  output logic [LINE_ADDR_W+$clog2(BEATS)-1:0]   mem_addr,
  input  logic                                   mem_ack,
  input  logic [WORD_W-1:0]                      mem_rdata
);

  localparam int unsigned CNT_W  = $clog2(BEATS);
  localparam int unsigned LINE_W = WORD_W * BEATS;

  typedef enum logic [1:0] {IDLE, FETCH, FILL} state_t;

  state_t                 state, state_d;
  logic [CNT_W-1:0]       cnt;
  logic [LINE_ADDR_W-1:0] line_q;
  logic [LINE_W-1:0]      data_q;
  logic [LINE_W-1:0]      fetched;
  logic                   capture;
  logic                   last_ack;
  logic                   hit;
  logic [LINE_W-1:0]      hit_data;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d      = state;
    capture      = 1'b0;
    last_ack     = 1'b0;
    l2_busy      = (state != IDLE);
    l2_rdy       = 1'b0;
    mem_wr_ic_en = 1'b0;
    mem_req      = 1'b0;
    case (state)
      IDLE: begin
        if (irq && (l2_cache_rw_ic == `READ)) begin
          capture = 1'b1;
          state_d = hit ? FILL : FETCH;
        end
      end
      FETCH: begin
        mem_req = 1'b1;
        if (mem_ack && (cnt == CNT_W'(BEATS - 1))) begin
          last_ack = 1'b1;
          // A withdrawn request still completes its beats but never presents the line.
          state_d  = irq ? FILL : IDLE;
        end
      end
      FILL: begin
        l2_rdy       = 1'b1;
        mem_wr_ic_en = 1'b1;
        if (complete_ic) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    fetched = data_q;
    fetched[WORD_W*cnt +: WORD_W] = mem_rdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      line_q <= '0;
      data_q <= '0;
    end else begin
      if (capture) begin
        line_q <= l2_addr_ic;
        cnt    <= '0;
        if (hit) data_q <= hit_data;
      end
      if (state == FETCH && mem_ack) begin
        data_q <= fetched;
        cnt    <= last_ack ? '0 : cnt + 1'b1;
      end
    end
  end

  assign mem_addr   = {line_q, cnt};
  assign data_wd_l2 = data_q;

`ifdef L2IC_LINEBUF_EN
  logic                   buf_valid;
  logic [LINE_ADDR_W-1:0] buf_line;
  logic [LINE_W-1:0]      buf_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_valid <= 1'b0;
      buf_line  <= '0;
      buf_data  <= '0;
    end else if (last_ack) begin
      buf_valid <= 1'b1;
      buf_line  <= line_q;
      buf_data  <= fetched;
    end
  end

  assign hit      = buf_valid && (buf_line == l2_addr_ic);
  assign hit_data = buf_data;
`else
  assign hit      = 1'b0;
  assign hit_data = '0;
`endif

endmodule

// File: tb/tb_l2_ic_resp.sv
// Directed-vector bench for l2_ic_resp; line-buffer vectors run when L2IC_LINEBUF_EN is defined.
`ifndef READ
`define READ 1'b1
`endif
`ifndef WRITE
`define WRITE 1'b0
`endif

module tb_l2_ic_resp;

  logic         clk = 1'b0;
  logic         rst;
  logic         irq;
  logic [27:0]  l2_addr_ic;
  logic         l2_cache_rw_ic;
  logic         complete_ic;
  logic         l2_busy;
  logic         l2_rdy;
  logic         mem_wr_ic_en;
  logic [127:0] data_wd_l2;
  logic         mem_req;
  logic [29:0]  mem_addr;
  logic         mem_ack;
  logic [31:0]  mem_rdata;

  int n_vec = 0;
  int n_err = 0;

  l2_ic_resp #(.LINE_ADDR_W(28), .WORD_W(32), .BEATS(4)) dut (
    .clk(clk), .rst(rst), .irq(irq), .l2_addr_ic(l2_addr_ic),
    .l2_cache_rw_ic(l2_cache_rw_ic), .complete_ic(complete_ic),
    .l2_busy(l2_busy), .l2_rdy(l2_rdy), .mem_wr_ic_en(mem_wr_ic_en),
    .data_wd_l2(data_wd_l2), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_outputs(input string tag);
    chk({tag, " busy"}, l2_busy, 1'b0);
    chk({tag, " rdy"}, l2_rdy, 1'b0);
    chk({tag, " wren"}, mem_wr_ic_en, 1'b0);
    chk({tag, " req"}, mem_req, 1'b0);
  endtask

  // Drives a read request; returns in cycle 1 (one edge after capture).
  task automatic issue(input logic [27:0] a);
    irq = 1'b1;
    l2_cache_rw_ic = `READ;
    l2_addr_ic = a;
    tick();
  endtask

  // Serves BEATS beats with 'waits' stall cycles each; irq drops together with beat drop_at (-1: never).
  task automatic run_fetch(input string tag, input logic [27:0] a, input logic [127:0] line,
                           input int waits, input int drop_at);
    logic [29:0] ea;
    for (int b = 0; b < 4; b++) begin
      ea = {a, 2'(b)};
      for (int w = 0; w < waits; w++) begin
        chk({tag, " stall req"}, mem_req, 1'b1);
        chk({tag, " stall addr"}, mem_addr, ea);
        chk({tag, " stall rdy"}, l2_rdy, 1'b0);
        tick();
      end
      chk({tag, " req"}, mem_req, 1'b1);
      chk({tag, " addr"}, mem_addr, ea);
      chk({tag, " busy"}, l2_busy, 1'b1);
      mem_ack = 1'b1;
      mem_rdata = line[32*b +: 32];
      if (b == drop_at) irq = 1'b0;
      tick();
      mem_ack = 1'b0;
      mem_rdata = 32'hDEAD_BEEF;
    end
    chk({tag, " req after"}, mem_req, 1'b0);
    if (drop_at < 0) begin
      chk({tag, " rdy"}, l2_rdy, 1'b1);
      chk({tag, " wren"}, mem_wr_ic_en, 1'b1);
      chk({tag, " data"}, data_wd_l2, line);
    end else begin
      idle_outputs({tag, " withdrawn"});
    end
  endtask

  // complete_ic with irq still high: FILL exits and the request must not be recaptured.
  task automatic finish_fill(input string tag, input logic [127:0] line);
    tick();
    chk({tag, " hold rdy"}, l2_rdy, 1'b1);
    chk({tag, " hold data"}, data_wd_l2, line);
    complete_ic = 1'b1;
    tick();
    complete_ic = 1'b0;
    irq = 1'b0;
    idle_outputs({tag, " done"});
  endtask

  logic [127:0] la, lb, lc, ld, le;

  initial begin
    la = {32'hA3A3_0003, 32'hA2A2_0002, 32'hA1A1_0001, 32'hA0A0_0000};
    lb = {32'hB3B3_1003, 32'hB2B2_1002, 32'hB1B1_1001, 32'hB0B0_1000};
    lc = {32'hC3C3_2003, 32'hC2C2_2002, 32'hC1C1_2001, 32'hC0C0_2000};
    ld = {32'hD3D3_3003, 32'hD2D2_3002, 32'hD1D1_3001, 32'hD0D0_3000};
    le = {32'hE3E3_4003, 32'hE2E2_4002, 32'hE1E1_4001, 32'hE0E0_4000};
    rst = 1'b1; irq = 1'b0; l2_addr_ic = '0; l2_cache_rw_ic = `READ;
    complete_ic = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
    tick(); tick();
    idle_outputs("reset");
    chk("reset data", data_wd_l2, 128'h0);
    rst = 1'b0;
    tick();

    // zero-wait fetch of line 0x10: l2_rdy in cycle 5
    issue(28'h0000010);
    run_fetch("t1", 28'h0000010, la, 0, -1);
    finish_fill("t1", la);

`ifdef L2IC_LINEBUF_EN
    issue(28'h0000010);
    chk("t5 hit req", mem_req, 1'b0);
    chk("t5 hit rdy", l2_rdy, 1'b1);
    chk("t5 hit data", data_wd_l2, la);
    finish_fill("t5 hit", la);
    issue(28'h0000011);
    run_fetch("t5 miss", 28'h0000011, le, 0, -1);
    finish_fill("t5 miss", le);
`endif

    // three stall cycles per beat
    issue(28'h0000020);
    run_fetch("t2", 28'h0000020, lb, 3, -1);
    finish_fill("t2", lb);

    // request withdrawn at beat 2
    issue(28'h0000030);
    run_fetch("t3", 28'h0000030, lc, 0, 2);
    tick();
    idle_outputs("t3 later");

    // reset during beat 1, late ack afterwards, then a clean restart
    issue(28'h0000050);
    chk("t4 addr0", mem_addr, 30'h140);
    mem_ack = 1'b1; mem_rdata = 32'h1111_1111;
    tick();
    chk("t4 addr1", mem_addr, 30'h141);
    rst = 1'b1;
    tick();
    rst = 1'b0; irq = 1'b0; mem_ack = 1'b0;
    idle_outputs("t4 rst");
    chk("t4 rst data", data_wd_l2, 128'h0);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    idle_outputs("t4 late ack");
    issue(28'h0000050);
    run_fetch("t4 restart", 28'h0000050, ld, 0, -1);
    finish_fill("t4 restart", ld);

    // write request and stray complete_ic in IDLE
    irq = 1'b1; l2_cache_rw_ic = `WRITE; l2_addr_ic = 28'h0000077; complete_ic = 1'b1;
    tick();
    idle_outputs("t6 a");
    tick();
    idle_outputs("t6 b");
    irq = 1'b0; complete_ic = 1'b0; l2_cache_rw_ic = `READ;
    tick();
    idle_outputs("t6 c");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
